// File: rtl/clk_divider.sv
// Integer clock divider: clk_out is a registered 50%-duty clock whose
// half-period is RATE cycles of clk_in. Asynchronous active-low reset.
module clk_divider #(
  parameter int RATE = 3
) (
  input  logic clk_in,
  input  logic rst,
  output logic clk_out
);

  localparam int unsigned CW = (RATE > 1) ? $clog2(RATE) : 1;
  localparam logic [CW-1:0] LAST = CW'(RATE - 1);

  // A half-period of zero or fewer input cycles has no meaning.
  if (RATE < 1) begin : g_rate_check
    $error("clk_divider: RATE must be >= 1");
  end

  logic [CW-1:0] cnt;

  // Count RATE input cycles per half-period and toggle the output on the wrap.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      clk_out <= 1'b0;
    end else if (cnt == LAST) begin
      cnt     <= '0;
      clk_out <= ~clk_out;
    end else begin
      cnt     <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_clk_divider.sv
// Bench for clk_divider: four instances (RATE 1, 3, 4, 5) share one clock and
// reset. Expected values come from the number of rising edges seen since
// reset release: out = (n / RATE) mod 2, cnt = n mod RATE.
module tb_clk_divider;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic out1, out3, out4, out5;

  int unsigned n = 0;
  int tests = 0;
  int fails = 0;

  clk_divider #(.RATE(1)) u_r1 (.clk_in(clk), .rst(rst_n), .clk_out(out1));
  clk_divider #(.RATE(3)) u_r3 (.clk_in(clk), .rst(rst_n), .clk_out(out3));
  clk_divider #(.RATE(4)) u_r4 (.clk_in(clk), .rst(rst_n), .clk_out(out4));
  clk_divider #(.RATE(5)) u_r5 (.clk_in(clk), .rst(rst_n), .clk_out(out5));

  always #10 clk = ~clk;

  // Edges seen with reset released; cleared whenever reset is asserted.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n <= 0;
    else        n <= n + 1;
  end

  // Edge counters and level-duration measurement for the long run.
  int  rises3 = 0;
  int  falls3 = 0;
  int  toggles3 = 0;
  time last_rise4 = 0, period4 = 0, high4 = 0;
  time last_rise5 = 0, period5 = 0, high5 = 0;

  always @(posedge out3) rises3++;
  always @(negedge out3) falls3++;
  always @(out3) toggles3++;
  always @(posedge out4) begin
    if (last_rise4 != 0) period4 = $time - last_rise4;
    last_rise4 = $time;
  end
  always @(negedge out4) if (rst_n) high4 = $time - last_rise4;
  always @(posedge out5) begin
    if (last_rise5 != 0) period5 = $time - last_rise5;
    last_rise5 = $time;
  end
  always @(negedge out5) if (rst_n) high5 = $time - last_rise5;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " out R1"}, int'(out1), int'((n / 1) % 2));
    chk({tag, " out R3"}, int'(out3), int'((n / 3) % 2));
    chk({tag, " out R4"}, int'(out4), int'((n / 4) % 2));
    chk({tag, " out R5"}, int'(out5), int'((n / 5) % 2));
    chk({tag, " cnt R1"}, int'(u_r1.cnt), 0);
    chk({tag, " cnt R3"}, int'(u_r3.cnt), int'(n % 3));
    chk({tag, " cnt R4"}, int'(u_r4.cnt), int'(n % 4));
    chk({tag, " cnt R5"}, int'(u_r5.cnt), int'(n % 5));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " out R1"}, int'(out1), 0);
    chk({tag, " out R3"}, int'(out3), 0);
    chk({tag, " out R4"}, int'(out4), 0);
    chk({tag, " out R5"}, int'(out5), 0);
    chk({tag, " cnt R3"}, int'(u_r3.cnt), 0);
    chk({tag, " cnt R4"}, int'(u_r4.cnt), 0);
    chk({tag, " cnt R5"}, int'(u_r5.cnt), 0);
  endtask

  typedef struct {
    int unsigned edges;
    logic e1, e3, e4, e5;
  } vec_t;

  vec_t vecs[12];

  initial begin
    // Hand-derived waveform after release, sampled mid-cycle after k edges.
    vecs[0]  = '{0,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{2,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{3,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{4,  1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{5,  1'b1, 1'b1, 1'b1, 1'b1};
    vecs[6]  = '{6,  1'b0, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{7,  1'b1, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{8,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{9,  1'b1, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{10, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{11, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset held for 3 cycles: outputs stay low with clock running.
    #1 check_zero("reset@start");
    repeat (3) begin
      @(negedge clk);
      check_zero("reset hold");
    end

    // Release and walk the table.
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i != 0) @(negedge clk);
      chk($sformatf("vec%0d R1", i), int'(out1), int'(vecs[i].e1));
      chk($sformatf("vec%0d R3", i), int'(out3), int'(vecs[i].e3));
      chk($sformatf("vec%0d R4", i), int'(out4), int'(vecs[i].e4));
      chk($sformatf("vec%0d R5", i), int'(out5), int'(vecs[i].e5));
    end

    // Async reset in the middle of an R3 high phase, away from any edge.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid-high R3 before", int'(out3), 1);
    #5 rst_n = 1'b0;
    #1 check_zero("async mid-high");
    repeat (3) begin
      @(negedge clk);
      check_zero("async hold");
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("restart edge%0d R3", k), int'(out3), (k == 3) ? 1 : 0);
    end

    // Reset coinciding with the edge where R3 would wrap and toggle.
    while (n % 3 != 2) @(negedge clk);
    chk("pre-wrap cnt R3", int'(u_r3.cnt), 2);
    @(posedge clk);
    rst_n = 1'b0;
    #1 check_zero("reset on wrap edge");
    @(negedge clk);
    check_zero("reset on wrap hold");

    // Randomised run/reset sequences against the edge-count model.
    for (int it = 0; it < 30; it++) begin
      int unsigned run_len, off, hold;
      run_len = $urandom_range(1, 25);
      off     = $urandom_range(1, 19);
      hold    = $urandom_range(1, 4);
      @(negedge clk);
      rst_n = 1'b1;
      check_model("rand release");
      repeat (run_len) begin
        @(negedge clk);
        check_model("rand run");
      end
      #(off) rst_n = 1'b0;
      #1 check_zero("rand async reset");
      repeat (hold) begin
        @(negedge clk);
        check_zero("rand hold");
      end
    end

    // Long run: 1000 edges with every level duration measured.
    @(negedge clk);
    rises3 = 0; falls3 = 0; toggles3 = 0;
    last_rise4 = 0; last_rise5 = 0;
    rst_n = 1'b1;
    repeat (1000) begin
      @(negedge clk);
      check_model("long");
    end
    chk("long rises R3",   rises3,   167);
    chk("long periods R3", falls3,   166);
    chk("long toggles R3", toggles3, 333);
    chk("period R4", int'(period4), 160);
    chk("high R4",   int'(high4),   80);
    chk("period R5", int'(period5), 200);
    chk("high R5",   int'(high5),   100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
